// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
// Decode-to-execute pipeline register of the five-stage RV32I core.
//
// Purpose:
//   Captures the decoded control bundle, register-file read data, extended
//   immediate, PC values and register indices at the end of decode and
//   presents them to execute one cycle later. Supports hazard-unit stall
//   (hold) and flush (bubble insertion) and carries a per-slot valid bit.
//
// Update priority on each rising clk edge (highest first):
//   reset_n = 0 -> clear everything
//   FlushE  = 1 -> load a bubble (all zeros, ValidE = 0)
//   StallE  = 1 -> hold
//   otherwise   -> load D inputs; an invalid slot (ValidD = 0) has its
//                  side-effecting control bits forced to 0.
//
// Ports:
//   clk, reset_n (sync, active-low), StallE, FlushE      : control
//   ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD : 1-bit D fields
//   ResultSrcD[1:0], ALUControlD[2:0]                     : select fields
//   RD1D, RD2D, ImmExtD, PCD, PCPlus4D [31:0]             : data fields
//   Rs1D, Rs2D, RdD [4:0]                                 : register indices
//   <name>E                                               : registered copies
//   FlushCntE[31:0]                                       : flush counter
//
// Configuration macro:
//   IDEX_FLUSH_CNT_EN - when defined, adds FlushCntE, a saturating count of
//   flush edges taken while out of reset. When undefined, the port and its
//   register are absent.
// -----------------------------------------------------------------------------
module id_ex_reg (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic        ValidD,
  input  logic        RegWriteD,
  input  logic        MemWriteD,
  input  logic        JumpD,
  input  logic        BranchD,
  input  logic        ALUSrcD,
  input  logic [1:0]  ResultSrcD,
  input  logic [2:0]  ALUControlD,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] ImmExtD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdD,
  output logic        ValidE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE
`ifdef IDEX_FLUSH_CNT_EN
  ,
  output logic [31:0] FlushCntE
`endif
);

  // Complete decode-slot payload carried across the pipeline boundary.
  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } idex_bundle_t;

  idex_bundle_t slot_in_s;
  idex_bundle_t slot_d;
  idex_bundle_t slot_q;

  // Gather the D-stage inputs into one bundle; invalid slots lose the
  // control bits that would otherwise write state or redirect the PC.
  always_comb begin
    slot_in_s             = '0;
    slot_in_s.valid       = ValidD;
    slot_in_s.alu_src     = ALUSrcD;
    slot_in_s.result_src  = ResultSrcD;
    slot_in_s.alu_control = ALUControlD;
    slot_in_s.rd1         = RD1D;
    slot_in_s.rd2         = RD2D;
    slot_in_s.imm_ext     = ImmExtD;
    slot_in_s.pc          = PCD;
    slot_in_s.pc_plus4    = PCPlus4D;
    slot_in_s.rs1         = Rs1D;
    slot_in_s.rs2         = Rs2D;
    slot_in_s.rd          = RdD;
    if (ValidD) begin
      slot_in_s.reg_write = RegWriteD;
      slot_in_s.mem_write = MemWriteD;
      slot_in_s.jump      = JumpD;
      slot_in_s.branch    = BranchD;
    end else begin
      slot_in_s.reg_write = 1'b0;
      slot_in_s.mem_write = 1'b0;
      slot_in_s.jump      = 1'b0;
      slot_in_s.branch    = 1'b0;
    end
  end

  // Next-slot selection: flush beats stall, stall beats load.
  always_comb begin
    slot_d = slot_q;
    if (FlushE) begin
      slot_d = '0;
    end else if (StallE) begin
      slot_d = slot_q;
    end else begin
      slot_d = slot_in_s;
    end
  end

  // Slot register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

`ifdef IDEX_FLUSH_CNT_EN
  logic [31:0] flush_cnt_d;
  logic [31:0] flush_cnt_q;

  // Count flush edges, saturating at all-ones; stall does not block it.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (FlushE) begin
      if (flush_cnt_q != 32'hFFFF_FFFF) begin
        flush_cnt_d = flush_cnt_q + 32'd1;
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Flush counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flush_cnt_q <= 32'd0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign FlushCntE = flush_cnt_q;
`endif

  // Outputs come straight from flops; no input reaches an output in the
  // same cycle.
  assign ValidE      = slot_q.valid;
  assign RegWriteE   = slot_q.reg_write;
  assign MemWriteE   = slot_q.mem_write;
  assign JumpE       = slot_q.jump;
  assign BranchE     = slot_q.branch;
  assign ALUSrcE     = slot_q.alu_src;
  assign ResultSrcE  = slot_q.result_src;
  assign ALUControlE = slot_q.alu_control;
  assign RD1E        = slot_q.rd1;
  assign RD2E        = slot_q.rd2;
  assign ImmExtE     = slot_q.imm_ext;
  assign PCE         = slot_q.pc;
  assign PCPlus4E    = slot_q.pc_plus4;
  assign Rs1E        = slot_q.rs1;
  assign Rs2E        = slot_q.rs2;
  assign RdE         = slot_q.rd;

endmodule
